keypad_lock: RTL and testbench

KEYPAD_LOCK -- requirements
Module: keypad_lock

---
 rtl/keypad_lock_pkg.sv | 29 ++
 rtl/lock_timer.sv | 38 +++
 rtl/keypad_lock.sv | 130 +++++++++++++
 tb/tb_keypad_lock.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/keypad_lock_pkg.sv
// Shared types and status codes for the keypad lock.
package keypad_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  localparam logic [1:0] SEG_IDLE  = 2'b10;
  localparam logic [1:0] SEG_ENTRY = 2'b00;
  localparam logic [1:0] SEG_OPEN  = 2'b01;
  localparam logic [1:0] SEG_LOCK  = 2'b11;

  function automatic logic [1:0] seg_of(input state_e s);
    case (s)
      ENTRY:   return SEG_ENTRY;
      OPEN:    return SEG_OPEN;
      LOCKOUT: return SEG_LOCK;
      default: return SEG_IDLE;
    endcase
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable saturating down-counter; done is registered and marks the final counted cycle.
module lock_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == W'(1));
    end
  end

  assign value_o = cnt_q;
  assign done_o  = done_q;

endmodule

// File: rtl/keypad_lock.sv
// Keypad code lock: collects CODE_LEN digits, opens on a match, locks out after MAX_FAIL misses.
module keypad_lock
  import keypad_lock_pkg::*;
#(
  parameter int unsigned                      CODE_LEN    = 4,
  parameter int unsigned                      DIGIT_W     = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]      CODE        = 16'hD3A1,
  parameter int unsigned                      MAX_FAIL    = 3,
  parameter int unsigned                      OPEN_CYCLES = 16,
  parameter int unsigned                      LOCK_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_clear,
  output logic               door_open,
  output logic [1:0]         seg_out,
  output logic [3:0]         fail_cnt
);

  localparam int unsigned BUF_W = CODE_LEN * DIGIT_W;
  localparam int unsigned IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned TMR_W = $clog2(max_u(OPEN_CYCLES, LOCK_CYCLES) + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BUF_W-1:0]   entry_q, entry_d, entry_w;
  logic [3:0]         fail_q, fail_d, fail_inc;
  logic               door_q;
  logic [1:0]         seg_q;
  logic               last_digit;
  logic               tmr_load, tmr_done, tmr_expired;
  logic [TMR_W-1:0]   tmr_load_val, tmr_value;

  lock_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .value_o    (tmr_value),
    .done_o     (tmr_done)
  );

  // A zero count in a timed state also exits, so the FSM can never stall there.
  assign tmr_expired = tmr_done || (tmr_value == '0);
  assign last_digit  = (idx_q == IDX_W'(CODE_LEN - 1));
  assign fail_inc    = fail_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    entry_d      = entry_q;
    fail_d       = fail_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    entry_w      = entry_q;
    // Digit i lands at nibble CODE_LEN-1-i so digit 0 ends up most significant.
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IDX_W'(i)) entry_w[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = key_digit;
    end

    case (state_q)
      IDLE, ENTRY: begin
        if (state_q == ENTRY && key_clear) begin
          state_d = IDLE;
          idx_d   = '0;
          entry_d = '0;
        end else if (key_valid && !key_clear) begin
          if (last_digit) begin
            // Single full-width compare: no hint about which digit was wrong.
            state_d = IDLE;
            idx_d   = '0;
            entry_d = '0;
            if (entry_w == CODE) begin
              state_d      = OPEN;
              fail_d       = 4'd0;
              tmr_load     = 1'b1;
              tmr_load_val = TMR_W'(OPEN_CYCLES);
            end else if (fail_inc >= 4'(MAX_FAIL)) begin
              state_d      = LOCKOUT;
              fail_d       = 4'(MAX_FAIL);
              tmr_load     = 1'b1;
              tmr_load_val = TMR_W'(LOCK_CYCLES);
            end else begin
              fail_d = fail_inc;
            end
          end else begin
            state_d = ENTRY;
            idx_d   = idx_q + IDX_W'(1);
            entry_d = entry_w;
          end
        end
      end
      OPEN: begin
        if (tmr_expired) state_d = IDLE;
      end
      LOCKOUT: begin
        if (tmr_expired) begin
          state_d = IDLE;
          fail_d  = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      entry_q <= '0;
      fail_q  <= 4'd0;
      door_q  <= 1'b0;
      seg_q   <= SEG_IDLE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
      fail_q  <= fail_d;
      door_q  <= (state_d == OPEN);
      seg_q   <= seg_of(state_d);
    end
  end

  assign door_open = door_q;
  assign seg_out   = seg_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_keypad_lock.sv
// Scoreboard bench for keypad_lock: each driven cycle queues the outputs expected after its edge.
module tb_keypad_lock;
  import keypad_lock_pkg::*;

  typedef struct {
    string      tag;
    logic [1:0] seg;
    logic       door;
    logic [3:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_clear = 1'b0;
  logic       door_open;
  logic [1:0] seg_out;
  logic [3:0] fail_cnt;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  keypad_lock #(
    .CODE_LEN(4), .DIGIT_W(4), .CODE(16'hD3A1),
    .MAX_FAIL(3), .OPEN_CYCLES(16), .LOCK_CYCLES(64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .key_clear (key_clear),
    .door_open (door_open),
    .seg_out   (seg_out),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  // Registered outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, ".seg"},  8'(seg_out),   8'(mon_e.seg));
      check({mon_e.tag, ".door"}, 8'(door_open), 8'(mon_e.door));
      check({mon_e.tag, ".fail"}, 8'(fail_cnt),  8'(mon_e.fc));
    end
  end

  task automatic step(input logic v, input logic [3:0] d, input logic c, input string tag,
                      input logic [1:0] s, input logic dr, input logic [3:0] f);
    exp_t e;
    @(negedge clk);
    key_valid = v;
    key_digit = d;
    key_clear = c;
    @(posedge clk);
    e.tag = tag; e.seg = s; e.door = dr; e.fc = f;
    sb.push_back(e);
  endtask

  task automatic hold(input int n, input string tag, input logic [1:0] s,
                      input logic dr, input logic [3:0] f);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, tag, s, dr, f);
  endtask

  // First three digits show ENTRY; the outcome of the fourth is supplied by the caller.
  task automatic enter(input logic [15:0] code, input string tag, input logic [3:0] fc_entry,
                       input logic [1:0] s_last, input logic dr_last, input logic [3:0] fc_last);
    for (int i = 0; i < 3; i++)
      step(1'b1, code[15-4*i -: 4], 1'b0, {tag, ".dig"}, SEG_ENTRY, 1'b0, fc_entry);
    step(1'b1, code[3:0], 1'b0, {tag, ".eval"}, s_last, dr_last, fc_last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst.seg",  8'(seg_out),   8'(SEG_IDLE));
    check("rst.door", 8'(door_open), 8'd0);
    check("rst.fail", 8'(fail_cnt),  8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(1, "post_rst", SEG_IDLE, 1'b0, 4'd0);

    // Correct code opens for exactly 16 cycles; keys during OPEN are ignored
    enter(16'hD3A1, "ok1", 4'd0, SEG_OPEN, 1'b1, 4'd0);
    step(1'b1, 4'hD, 1'b0, "open_key", SEG_OPEN, 1'b1, 4'd0);
    step(1'b0, 4'h0, 1'b1, "open_clr", SEG_OPEN, 1'b1, 4'd0);
    hold(13, "open1", SEG_OPEN, 1'b1, 4'd0);
    hold(2, "close1", SEG_IDLE, 1'b0, 4'd0);

    // Three wrong entries -> lockout for 64 cycles, keys ignored, then fail_cnt cleared
    enter(16'hD3A2, "bad1", 4'd0, SEG_IDLE, 1'b0, 4'd1);
    enter(16'hD3A2, "bad2", 4'd1, SEG_IDLE, 1'b0, 4'd2);
    enter(16'hD3A2, "bad3", 4'd2, SEG_LOCK, 1'b0, 4'd3);
    step(1'b1, 4'hD, 1'b0, "lock_key", SEG_LOCK, 1'b0, 4'd3);
    step(1'b1, 4'h3, 1'b0, "lock_key", SEG_LOCK, 1'b0, 4'd3);
    step(1'b1, 4'hA, 1'b0, "lock_key", SEG_LOCK, 1'b0, 4'd3);
    step(1'b1, 4'h1, 1'b0, "lock_key", SEG_LOCK, 1'b0, 4'd3);
    step(1'b0, 4'h0, 1'b1, "lock_clr", SEG_LOCK, 1'b0, 4'd3);
    hold(58, "lock", SEG_LOCK, 1'b0, 4'd3);
    hold(1, "unlock", SEG_IDLE, 1'b0, 4'd0);

    // Partial entry cleared, then a correct code opens with fail_cnt unchanged
    step(1'b1, 4'hD, 1'b0, "part", SEG_ENTRY, 1'b0, 4'd0);
    step(1'b1, 4'h3, 1'b0, "part", SEG_ENTRY, 1'b0, 4'd0);
    step(1'b0, 4'h0, 1'b1, "clr", SEG_IDLE, 1'b0, 4'd0);
    enter(16'hD3A1, "ok2", 4'd0, SEG_OPEN, 1'b1, 4'd0);
    hold(15, "open2", SEG_OPEN, 1'b1, 4'd0);
    hold(1, "close2", SEG_IDLE, 1'b0, 4'd0);

    // First-digit mismatch, then clear wins over the 4th digit, then index restarts at 0
    enter(16'h03A1, "bad4", 4'd0, SEG_IDLE, 1'b0, 4'd1);
    step(1'b1, 4'hD, 1'b0, "vc", SEG_ENTRY, 1'b0, 4'd1);
    step(1'b1, 4'h3, 1'b0, "vc", SEG_ENTRY, 1'b0, 4'd1);
    step(1'b1, 4'hA, 1'b0, "vc", SEG_ENTRY, 1'b0, 4'd1);
    step(1'b1, 4'h1, 1'b1, "vc_both", SEG_IDLE, 1'b0, 4'd1);
    hold(1, "vc_idle", SEG_IDLE, 1'b0, 4'd1);
    enter(16'hD3A1, "ok3", 4'd1, SEG_OPEN, 1'b1, 4'd0);
    hold(15, "open3", SEG_OPEN, 1'b1, 4'd0);
    hold(1, "close3", SEG_IDLE, 1'b0, 4'd0);

    // Reset during the 5th OPEN cycle, then a fresh code opens normally
    enter(16'hD3A1, "ok4", 4'd0, SEG_OPEN, 1'b1, 4'd0);
    hold(4, "open4", SEG_OPEN, 1'b1, 4'd0);
    @(negedge clk);
    key_valid = 1'b0;
    key_clear = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.seg",  8'(seg_out),   8'(SEG_IDLE));
    check("mid_rst.door", 8'(door_open), 8'd0);
    check("mid_rst.fail", 8'(fail_cnt),  8'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    hold(2, "after_rst", SEG_IDLE, 1'b0, 4'd0);
    enter(16'hD3A1, "ok5", 4'd0, SEG_OPEN, 1'b1, 4'd0);
    hold(15, "open5", SEG_OPEN, 1'b1, 4'd0);
    hold(1, "close5", SEG_IDLE, 1'b0, 4'd0);

    repeat (2) @(negedge clk);
    #1;
    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
